// File: rtl/data_store_buffer.sv
// rtl/data_store_buffer.sv - posted-write store buffer between core data port and memory master
// Optional store-to-load forwarding from the FIFO is built when STORE_FWD_EN is defined.
module data_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_start,
  input  logic                   core_write,
  input  logic [29:0]            core_addr,
  input  logic [31:0]            core_data_wr,
  input  logic [3:0]             core_data_be,
  output logic                   core_ready,
  output logic [31:0]            core_data_rd,
  output logic                   mem_start,
  output logic                   mem_write,
  output logic [29:0]            mem_addr,
  output logic [31:0]            mem_data_wr,
  output logic [3:0]             mem_data_be,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_data_rd,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {C_IDLE, C_WR_HOLD, C_RD_PEND, C_RESP} core_state_e;
  typedef enum logic [1:0] {M_IDLE, M_WR_WAIT, M_RD_WAIT} mem_state_e;

  core_state_e core_q, core_d;
  mem_state_e  mem_q, mem_d;

  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
  logic [29:0]   req_addr_q, req_addr_d;
  logic [31:0]   req_data_q, req_data_d;
  logic [3:0]    req_be_q, req_be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mstart_q, mstart_d, mwrite_q, mwrite_d;
  logic [29:0]   maddr_q, maddr_d;
  logic [31:0]   mdata_q, mdata_d;
  logic [3:0]    mbe_q, mbe_d;

  logic [29:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [3:0]    fifo_be_q   [DEPTH];

  logic          push, pop;
  logic [29:0]   push_addr;
  logic [31:0]   push_data;
  logic [3:0]    push_be;

  // Occupancy is the pointer difference; the extra pointer bit separates full from empty.
  assign fill = wr_ptr_q - rd_ptr_q;

`ifdef STORE_FWD_EN
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [AW-1:0] fwd_idx;

  // Scan oldest to youngest so the last match wins; only a full-word youngest match forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q[AW-1:0] + AW'(i);
      if ((LW'(i) < fill) && (fifo_addr_q[fwd_idx] == core_addr)) begin
        fwd_hit  = (fifo_be_q[fwd_idx] == 4'hF);
        fwd_data = fifo_data_q[fwd_idx];
      end
    end
  end
`endif

  always_comb begin
    core_d     = core_q;
    push       = 1'b0;
    push_addr  = core_addr;
    push_data  = core_data_wr;
    push_be    = core_data_be;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_be_d   = req_be_q;
    rdata_d    = rdata_q;
    case (core_q)
      C_IDLE: begin
        if (core_start) begin
          req_addr_d = core_addr;
          req_data_d = core_data_wr;
          req_be_d   = core_data_be;
          if (core_write) begin
            if (fill < FULL_LVL) begin
              push   = 1'b1;
              core_d = C_RESP;
            end else begin
              core_d = C_WR_HOLD;
            end
          end else begin
`ifdef STORE_FWD_EN
            if (fwd_hit) begin
              rdata_d = fwd_data;
              core_d  = C_RESP;
            end else begin
              core_d  = C_RD_PEND;
            end
`else
            core_d = C_RD_PEND;
`endif
          end
        end
      end
      C_WR_HOLD: begin
        push_addr = req_addr_q;
        push_data = req_data_q;
        push_be   = req_be_q;
        if (fill < FULL_LVL) begin
          push   = 1'b1;
          core_d = C_RESP;
        end
      end
      C_RD_PEND: begin
        if ((mem_q == M_RD_WAIT) && mem_ready) begin
          rdata_d = mem_data_rd;
          core_d  = C_RESP;
        end
      end
      C_RESP:  core_d = C_IDLE;
      default: core_d = C_IDLE;
    endcase
  end

  // Draining stores always wins; a pending load only goes out once the FIFO is empty.
  always_comb begin
    mem_d    = mem_q;
    pop      = 1'b0;
    mstart_d = 1'b0;
    mwrite_d = mwrite_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    mbe_d    = mbe_q;
    case (mem_q)
      M_IDLE: begin
        if (fill != '0) begin
          pop      = 1'b1;
          mstart_d = 1'b1;
          mwrite_d = 1'b1;
          maddr_d  = fifo_addr_q[rd_ptr_q[AW-1:0]];
          mdata_d  = fifo_data_q[rd_ptr_q[AW-1:0]];
          mbe_d    = fifo_be_q[rd_ptr_q[AW-1:0]];
          mem_d    = M_WR_WAIT;
        end else if (core_q == C_RD_PEND) begin
          mstart_d = 1'b1;
          mwrite_d = 1'b0;
          maddr_d  = req_addr_q;
          mdata_d  = '0;
          mbe_d    = 4'hF;
          mem_d    = M_RD_WAIT;
        end
      end
      M_WR_WAIT, M_RD_WAIT: begin
        if (mem_ready) mem_d = M_IDLE;
      end
      default: mem_d = M_IDLE;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + LW'(push);
  assign rd_ptr_d = rd_ptr_q + LW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_q     <= C_IDLE;
      mem_q      <= M_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_be_q   <= '0;
      rdata_q    <= '0;
      mstart_q   <= 1'b0;
      mwrite_q   <= 1'b0;
      maddr_q    <= '0;
      mdata_q    <= '0;
      mbe_q      <= '0;
    end else begin
      core_q     <= core_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_be_q   <= req_be_d;
      rdata_q    <= rdata_d;
      mstart_q   <= mstart_d;
      mwrite_q   <= mwrite_d;
      maddr_q    <= maddr_d;
      mdata_q    <= mdata_d;
      mbe_q      <= mbe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[AW-1:0]] <= push_addr;
      fifo_data_q[wr_ptr_q[AW-1:0]] <= push_data;
      fifo_be_q[wr_ptr_q[AW-1:0]]   <= push_be;
    end
  end

  assign core_ready   = (core_q == C_RESP);
  assign core_data_rd = rdata_q;
  assign mem_start    = mstart_q;
  assign mem_write    = mwrite_q;
  assign mem_addr     = maddr_q;
  assign mem_data_wr  = mdata_q;
  assign mem_data_be  = mbe_q;
  assign empty        = (fill == '0) && (mem_q != M_WR_WAIT);
  assign level        = fill;

endmodule

// File: tb/tb_data_store_buffer.sv
// tb/tb_data_store_buffer.sv - directed self-checking bench for data_store_buffer
// Forwarding steps are compiled in when STORE_FWD_EN is defined.
module tb_data_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_start = 1'b0;
  logic        core_write = 1'b0;
  logic [29:0] core_addr = '0;
  logic [31:0] core_data_wr = '0;
  logic [3:0]  core_data_be = '0;
  logic        core_ready;
  logic [31:0] core_data_rd;
  logic        mem_start;
  logic        mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_wr;
  logic [3:0]  mem_data_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data_rd = '0;
  logic        empty;
  logic [2:0]  level;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen;

  data_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_start(core_start), .core_write(core_write), .core_addr(core_addr),
    .core_data_wr(core_data_wr), .core_data_be(core_data_be),
    .core_ready(core_ready), .core_data_rd(core_data_rd),
    .mem_start(mem_start), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_wr(mem_data_wr), .mem_data_be(mem_data_be),
    .mem_ready(mem_ready), .mem_data_rd(mem_data_rd),
    .empty(empty), .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic core_req(input logic wr, input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    core_start   = 1'b1;
    core_write   = wr;
    core_addr    = a;
    core_data_wr = d;
    core_data_be = be;
    tick();
    core_start   = 1'b0;
  endtask

  task automatic mem_ack(input logic [31:0] d);
    mem_ready   = 1'b1;
    mem_data_rd = d;
    tick();
    mem_ready   = 1'b0;
  endtask

  task automatic wait_mem_start(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_start;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_core_ready", 32'(core_ready), 0);
    chk("rst_mem_start", 32'(mem_start), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_data_rd", core_data_rd, 0);
    chk("rst_mem_be", 32'(mem_data_be), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single store, then drain
    core_req(1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
    chk("t1_ack", 32'(core_ready), 1);
    chk("t1_level", 32'(level), 1);
    chk("t1_no_mstart_yet", 32'(mem_start), 0);
    tick();
    chk("t1_mstart", 32'(mem_start), 1);
    chk("t1_maddr", 32'(mem_addr), 32'h10);
    chk("t1_mwrite", 32'(mem_write), 1);
    chk("t1_mdata", mem_data_wr, 32'hDEADBEEF);
    chk("t1_ack_gone", 32'(core_ready), 0);
    chk("t1_not_empty", 32'(empty), 0);
    mem_ack(32'h0);
    chk("t1_empty", 32'(empty), 1);

    // stall memory: one store in flight plus four queued, sixth waits for a slot
    for (int i = 0; i < 5; i++) begin
      core_req(1'b1, 30'h40 + 30'(i), 32'h1000 + 32'(i), 4'hF);
      chk("t2_ack", 32'(core_ready), 1);
      tick();
      if (i == 0) chk("t2_first_addr", 32'(mem_addr), 32'h40);
    end
    chk("t2_level_full", 32'(level), 4);
    core_req(1'b1, 30'h45, 32'h1005, 4'hF);
    chk("t2_held", 32'(core_ready), 0);
    tick();
    tick();
    chk("t2_still_held", 32'(core_ready), 0);
    mem_ack(32'h0);
    chk("t2_no_ack_on_ready", 32'(core_ready), 0);
    tick();
    chk("t2_mstart2", 32'(mem_start), 1);
    chk("t2_addr2", 32'(mem_addr), 32'h41);
    chk("t2_level_popped", 32'(level), 3);
    chk("t2_no_ack_on_pop", 32'(core_ready), 0);
    tick();
    chk("t2_held_ack", 32'(core_ready), 1);
    chk("t2_level_refill", 32'(level), 4);
    for (int i = 2; i < 6; i++) begin
      mem_ack(32'h0);
      wait_mem_start("t2_drain_start");
      chk("t2_drain_addr", 32'(mem_addr), 32'h40 + 32'(i));
      chk("t2_drain_data", mem_data_wr, 32'h1000 + 32'(i));
    end
    mem_ack(32'h0);
    chk("t2_empty", 32'(empty), 1);

    // load waits for three older stores
    for (int i = 0; i < 3; i++) begin
      core_req(1'b1, 30'h50 + 30'(i), 32'h2000 + 32'(i), 4'hF);
      tick();
    end
    core_req(1'b0, 30'h20, 32'h0, 4'h0);
    chk("t3_load_pending", 32'(core_ready), 0);
    mem_ack(32'h0);
    wait_mem_start("t3_st2_start");
    chk("t3_st2_write", 32'(mem_write), 1);
    chk("t3_st2_addr", 32'(mem_addr), 32'h51);
    mem_ack(32'h0);
    wait_mem_start("t3_st3_start");
    chk("t3_st3_write", 32'(mem_write), 1);
    chk("t3_st3_addr", 32'(mem_addr), 32'h52);
    mem_ack(32'h0);
    wait_mem_start("t3_ld_start");
    chk("t3_ld_write", 32'(mem_write), 0);
    chk("t3_ld_addr", 32'(mem_addr), 32'h20);
    chk("t3_ld_be", 32'(mem_data_be), 32'hF);
    mem_ack(32'h12345678);
    chk("t3_ld_ack", 32'(core_ready), 1);
    chk("t3_ld_data", core_data_rd, 32'h12345678);
    tick();
    chk("t3_ack_pulse", 32'(core_ready), 0);
    chk("t3_data_held", core_data_rd, 32'h12345678);

    // full-word store still queued behind a stalled store, then load to the same address
    core_req(1'b1, 30'h60, 32'h3000, 4'hF);
    tick();
    core_req(1'b1, 30'h30, 32'hCAFEF00D, 4'hF);
    tick();
    core_req(1'b0, 30'h30, 32'h0, 4'h0);
`ifdef STORE_FWD_EN
    chk("t4_fwd_ack", 32'(core_ready), 1);
    chk("t4_fwd_data", core_data_rd, 32'hCAFEF00D);
    chk("t4_fwd_no_mstart", 32'(mem_start), 0);
    tick();
    mem_ack(32'h0);
    wait_mem_start("t4_st_start");
    chk("t4_st_addr", 32'(mem_addr), 32'h30);
    mem_ack(32'h0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | mem_start;
    end
    chk("t4_no_load_on_mem", 32'(seen), 0);
`else
    chk("t4_no_fwd", 32'(core_ready), 0);
    mem_ack(32'h0);
    wait_mem_start("t4_st_start");
    chk("t4_st_addr", 32'(mem_addr), 32'h30);
    mem_ack(32'h0);
    wait_mem_start("t4_ld_start");
    chk("t4_ld_write", 32'(mem_write), 0);
    mem_ack(32'h55AA55AA);
    chk("t4_ld_data", core_data_rd, 32'h55AA55AA);
    tick();
`endif

    // partial-be match never forwards
    core_req(1'b1, 30'h70, 32'h4000, 4'hF);
    tick();
    core_req(1'b1, 30'h30, 32'h00001111, 4'b0011);
    tick();
    core_req(1'b0, 30'h30, 32'h0, 4'h0);
    chk("t5_no_fwd", 32'(core_ready), 0);
    mem_ack(32'h0);
    wait_mem_start("t5_st_start");
    chk("t5_st_addr", 32'(mem_addr), 32'h30);
    chk("t5_st_be", 32'(mem_data_be), 32'h3);
    mem_ack(32'h0);
    wait_mem_start("t5_ld_start");
    chk("t5_ld_write", 32'(mem_write), 0);
    chk("t5_ld_addr", 32'(mem_addr), 32'h30);
    mem_ack(32'h0BADF00D);
    chk("t5_ld_ack", 32'(core_ready), 1);
    chk("t5_ld_data", core_data_rd, 32'h0BADF00D);
    tick();

    // reset while a store is in flight and two are queued
    for (int i = 0; i < 3; i++) begin
      core_req(1'b1, 30'h80 + 30'(i), 32'h5000 + 32'(i), 4'hF);
      tick();
    end
    chk("t6_level_pre", 32'(level), 2);
    chk("t6_busy_pre", 32'(empty), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_level", 32'(level), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_core_ready", 32'(core_ready), 0);
    chk("t6_data_rd", core_data_rd, 0);
    chk("t6_mem_addr", 32'(mem_addr), 0);
    chk("t6_mem_write", 32'(mem_write), 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | mem_start;
    end
    chk("t6_no_mstart", 32'(seen), 0);
    chk("t6_level_after", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
